// File: rtl/voice_allocator_if.sv
// Note-event handshake bus between the MIDI decoder and the voice allocator.
`timescale 1ns/1ps
interface voice_allocator_if #(
    parameter int unsigned NOTE_WIDTH     = 7,
    parameter int unsigned VELOCITY_WIDTH = 7
);
    logic                      ev_valid;
    logic                      ev_ready;
    logic                      ev_note_on;
    logic [NOTE_WIDTH-1:0]     ev_note;
    logic [VELOCITY_WIDTH-1:0] ev_velocity;

    modport master (output ev_valid, ev_note_on, ev_note, ev_velocity, input ev_ready);
    modport slave  (input ev_valid, ev_note_on, ev_note, ev_velocity, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto a voice table.
// Define VOICE_STEAL_EN to steal the oldest voice when a note-on finds none free.
`timescale 1ns/1ps
module voice_allocator #(
    parameter int unsigned VOICE_COUNT    = 8,
    parameter int unsigned NOTE_WIDTH     = 7,
    parameter int unsigned VELOCITY_WIDTH = 7
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    voice_allocator_if.slave                             ev,
    output logic [VOICE_COUNT-1:0]                       voice_active,
    output logic [VOICE_COUNT-1:0][NOTE_WIDTH-1:0]       voice_note,
    output logic [VOICE_COUNT-1:0][VELOCITY_WIDTH-1:0]   voice_velocity,
    output logic                                         upd_valid,
    output logic [$clog2(VOICE_COUNT)-1:0]               upd_index,
    output logic                                         ev_dropped
);
    localparam int unsigned IDX_W = $clog2(VOICE_COUNT);
    localparam int unsigned AGE_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

    state_t                           state, state_nxt;
    logic [NOTE_WIDTH-1:0]            note_q;
    logic [VELOCITY_WIDTH-1:0]        vel_q;
    logic                             on_q;
    logic [VOICE_COUNT-1:0][AGE_W-1:0] age;

    logic             hit_c, free_c, wr_c;
    logic [IDX_W-1:0] hit_idx_c, free_idx_c, wr_idx_c;
`ifdef VOICE_STEAL_EN
    logic             old_found_c;
    logic [IDX_W-1:0] old_idx_c;
    logic [AGE_W-1:0] old_age_c;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and ready
    always_comb begin
        state_nxt   = state;
        ev.ev_ready = 1'b0;
        case (state)
            IDLE: begin
                ev.ev_ready = 1'b1;
                if (ev.ev_valid) state_nxt = LOOKUP;
            end
            LOOKUP:  state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Event capture; velocity-0 note-on behaves as note-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_q <= '0;
            vel_q  <= '0;
            on_q   <= 1'b0;
        end else if (state == IDLE && ev.ev_valid) begin
            note_q <= ev.ev_note;
            vel_q  <= ev.ev_velocity;
            on_q   <= ev.ev_note_on && (ev.ev_velocity != '0);
        end
    end

    // Table search: descending scan leaves the lowest matching index
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = int'(VOICE_COUNT) - 1; i >= 0; i--) begin
            if (voice_active[i] && voice_note[i] == note_q) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!voice_active[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Oldest active voice; strict compare keeps the lowest index on ties
    always_comb begin
        old_found_c = 1'b0;
        old_idx_c   = '0;
        old_age_c   = '0;
        for (int i = 0; i < int'(VOICE_COUNT); i++) begin
            if (voice_active[i] && (!old_found_c || age[i] > old_age_c)) begin
                old_found_c = 1'b1;
                old_idx_c   = IDX_W'(i);
                old_age_c   = age[i];
            end
        end
    end
`endif

    // Target voice for this event, if any
    always_comb begin
        wr_c     = 1'b0;
        wr_idx_c = '0;
        if (hit_c) begin
            wr_c     = 1'b1;
            wr_idx_c = hit_idx_c;
        end else if (on_q && free_c) begin
            wr_c     = 1'b1;
            wr_idx_c = free_idx_c;
        end
`ifdef VOICE_STEAL_EN
        else if (on_q) begin
            wr_c     = 1'b1;
            wr_idx_c = old_idx_c;
        end
`endif
    end

    // Decision registered at end of LOOKUP so the pulses cover UPDATE only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid  <= 1'b0;
            upd_index  <= '0;
            ev_dropped <= 1'b0;
        end else begin
            upd_valid  <= 1'b0;
            ev_dropped <= 1'b0;
            if (state == LOOKUP) begin
                upd_valid  <= wr_c;
                ev_dropped <= !wr_c;
                if (wr_c) upd_index <= wr_idx_c;
            end
        end
    end

    // Table write; note-off keeps note/velocity for the release phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_active   <= '0;
            voice_note     <= '0;
            voice_velocity <= '0;
            age            <= '0;
        end else if (state == UPDATE && upd_valid) begin
            if (on_q) begin
                for (int i = 0; i < int'(VOICE_COUNT); i++) begin
                    if (IDX_W'(i) == upd_index) begin
                        voice_active[i]   <= 1'b1;
                        voice_note[i]     <= note_q;
                        voice_velocity[i] <= vel_q;
                        age[i]            <= '0;
                    end else if (voice_active[i] && age[i] != '1) begin
                        age[i] <= age[i] + AGE_W'(1);
                    end
                end
            end else begin
                voice_active[upd_index] <= 1'b0;
            end
        end
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Upstream stage of the dispatcher: consumes decoded MIDI note events and maintains the voice table that the note search scans.
- Maps each note-on to a voice and each note-off to the voice holding that note.
- Exports per-voice note, velocity and active state to the synth voices.
- Looks up notes with an internal combinational search over the voice table.

Parameters:
- VOICE_COUNT, 8, number of polyphonic voices (>=2).
- NOTE_WIDTH, 7, MIDI note number width.
- VELOCITY_WIDTH, 7, MIDI velocity width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ev_valid  input  1  event valid.
- ev_ready  output  1  event accepted when ev_valid&&ev_ready.
- ev_note_on  input  1  1=note-on, 0=note-off.
- ev_note  input  NOTE_WIDTH  note number.
- ev_velocity  input  VELOCITY_WIDTH  velocity.
- voice_active  output  VOICE_COUNT  per-voice gate.
- voice_note  output  NOTE_WIDTH x VOICE_COUNT  per-voice note.
- voice_velocity  output  VELOCITY_WIDTH x VOICE_COUNT  per-voice velocity.
- upd_valid  output  1  one-cycle pulse: a voice entry changed.
- upd_index  output  $clog2(VOICE_COUNT)  voice that changed.
- ev_dropped  output  1  one-cycle pulse: event discarded.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - voice_active=0; all voice_note and voice_velocity=0; all ages=0.
  - upd_valid=0, upd_index=0, ev_dropped=0.
  - ev_ready=1 (combinational from IDLE).
- Reset mid-operation aborts the event in flight with no table write.
- FSM IDLE -> LOOKUP -> UPDATE -> IDLE. ev_ready=1 only in IDLE, so at most one event per 3 cycles.
- IDLE: on handshake, register note, velocity and kind.
  - Note-on with velocity 0 is treated as note-off.
- LOOKUP: register the search results:
  - hit/hit_idx: lowest-index active voice whose note equals the event note.
  - free/free_idx: lowest-index inactive voice.
  - old_idx: active voice with the largest age; ties go to the lowest index.
- UPDATE: write the table, drive outputs for exactly this one cycle, then return to IDLE.
  - Note-on, hit: retrigger hit_idx. Velocity is overwritten, active stays 1, age reset to 0. upd_valid=1, upd_index=hit_idx.
  - Note-on, no hit, free: allocate free_idx with note, velocity, active=1, age=0. upd_valid=1, upd_index=free_idx.
  - Note-on, no hit, no free: see Optional Feature.
  - Note-off, hit: clear voice_active[hit_idx]; note and velocity are retained for release. upd_valid=1, upd_index=hit_idx.
  - Note-off, miss: no write, ev_dropped=1.
- Ages:
  - Width $clog2(VOICE_COUNT)+1, saturating at all-ones.
  - On every note-on that writes a voice, all other active voices increment their age; the written voice gets age 0.
  - Inactive voices hold their age.
- Table registers are visible on outputs the cycle after UPDATE.
- upd_valid and ev_dropped are never asserted together. Both are 0 outside UPDATE.
- Changes to ev_* while ev_ready=0 are ignored.

Optional Feature:
- VOICE_STEAL_EN defined: a note-on with no hit and no free voice steals old_idx.
  - Writes the new note and velocity, age=0, active stays 1; other active voices age.
  - upd_valid=1, upd_index=old_idx.
- Undefined: that event is discarded. ev_dropped=1, no table write, upd_valid=0.

Test Plan:
- Reset, then note-on 60/vel 100 -> after 3 cycles voice 0 active, note 60, vel 100; upd_valid pulse with upd_index=0; ev_ready high again.
- Note-on 60, 64, 67, then note-off 64 -> voices 0,1,2 allocated; the note-off gives upd_index=1; voice_active=3'b101 in the low bits; voice_note[1] stays 64.
- Note-on 60/vel 100, then note-on 60/vel 20 -> second event gives upd_index=0, voice_velocity[0]=20; no new voice allocated.
- Note-off 72 with no voice holding it -> ev_dropped pulse for 1 cycle; table unchanged; upd_valid stays 0.
- Fill all 8 voices with notes 40..47, then note-on 50:
  - With VOICE_STEAL_EN: voice 0 (oldest) gets note 50, upd_index=0.
  - Without: ev_dropped pulse, table unchanged.
- Hold ev_valid=1 continuously with 4 events, asserting rst_n=0 during LOOKUP of the second event -> table cleared immediately; the second event is lost; after release ev_ready=1 and the next event is allocated to voice 0.
